// File: rtl/elevator_car_controller_if.sv
// Call-in / status-out bundle between the hall-call decoder side and the car controller.
// The controller uses the slave view; the call source and the observers use the master view.
interface elevator_car_controller_if;
  logic [1:0] up_or_down;
  logic [1:0] call_floor;
  logic [1:0] current_floor;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic [3:0] pending;
  logic       busy;

  modport master (
    output up_or_down, call_floor,
    input  current_floor, motor_up, motor_down, door_open, pending, busy
  );

  modport slave (
    input  up_or_down, call_floor,
    output current_floor, motor_up, motor_down, door_open, pending, busy
  );
endinterface

// File: rtl/elevator_car_controller.sv
// Four-floor collective-sweep car controller: latches hall calls, times floor-to-floor
// travel and door dwell, and drives motor, door and floor-display outputs.
module elevator_car_controller #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int CNT_W         = 27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  elevator_car_controller_if.slave  ctrl
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_MOVING_UP   = 2'd1,
    ST_MOVING_DOWN = 2'd2,
    ST_DOOR_OPEN   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_floor;
  logic [3:0]       r_pending;
  logic [CNT_W-1:0] r_timer;
  logic             r_last_dir;

  state_t           w_state_next;
  logic [1:0]       w_floor_next;
  logic [3:0]       w_pending_next;
  logic [CNT_W-1:0] w_timer_next;
  logic             w_last_dir_next;

  logic             w_valid;
  logic             w_same_floor_call;
  logic             w_latch;
  logic [3:0]       w_call_oh;
  logic [3:0]       w_above_mask;
  logic [3:0]       w_below_mask;
  logic             w_above;
  logic             w_below;
  logic             w_go_up;
  logic             w_go_down;
  logic [1:0]       w_step_floor;
  logic [3:0]       w_step_oh;
  logic [3:0]       w_clear_oh;
  logic             w_at_rest;

  // 10 is a reserved decoder code and never counts as a call.
  assign w_valid = (ctrl.up_or_down == 2'b01) || (ctrl.up_or_down == 2'b11);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_floor_masks
      assign w_call_oh[gi]    = (ctrl.call_floor == 2'(gi));
      assign w_above_mask[gi] = (r_floor < 2'(gi));
      assign w_below_mask[gi] = (r_floor > 2'(gi));
      assign w_step_oh[gi]    = (w_step_floor == 2'(gi));
    end
  endgenerate

  assign w_above = |(r_pending & w_above_mask);
  assign w_below = |(r_pending & w_below_mask);

  // Keep sweeping the same way while work remains there; otherwise reverse.
  assign w_go_up   = (r_last_dir == DIR_UP)   ? w_above : (w_above && !w_below);
  assign w_go_down = (r_last_dir == DIR_DOWN) ? w_below : (w_below && !w_above);

  assign w_at_rest         = (r_state == ST_IDLE) || (r_state == ST_DOOR_OPEN);
  assign w_same_floor_call = w_valid && (ctrl.call_floor == r_floor);
  assign w_latch           = w_valid && !(w_at_rest && (ctrl.call_floor == r_floor));

  assign w_step_floor = (r_state == ST_MOVING_UP) ? (r_floor + 2'd1) : (r_floor - 2'd1);

  always_comb begin
    w_state_next    = r_state;
    w_floor_next    = r_floor;
    w_timer_next    = r_timer;
    w_last_dir_next = r_last_dir;
    w_clear_oh      = 4'b0000;

    unique case (r_state)
      ST_IDLE: begin
        if (w_same_floor_call) begin
          w_state_next = ST_DOOR_OPEN;
          w_timer_next = DOOR_LOAD;
        end else if (w_go_up) begin
          w_state_next    = ST_MOVING_UP;
          w_timer_next    = TRAVEL_LOAD;
          w_last_dir_next = DIR_UP;
        end else if (w_go_down) begin
          w_state_next    = ST_MOVING_DOWN;
          w_timer_next    = TRAVEL_LOAD;
          w_last_dir_next = DIR_DOWN;
        end
      end

      ST_MOVING_UP, ST_MOVING_DOWN: begin
        if (r_timer == '0) begin
          w_floor_next = w_step_floor;
          if (|(r_pending & w_step_oh)) begin
            w_clear_oh   = w_step_oh;
            w_state_next = ST_DOOR_OPEN;
            w_timer_next = DOOR_LOAD;
          end else begin
            w_timer_next = TRAVEL_LOAD;
          end
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end

      ST_DOOR_OPEN: begin
        // A same-floor call holds the door by restarting the dwell.
        if (w_same_floor_call) begin
          w_timer_next = DOOR_LOAD;
        end else if (r_timer == '0) begin
          if (w_go_up) begin
            w_state_next    = ST_MOVING_UP;
            w_timer_next    = TRAVEL_LOAD;
            w_last_dir_next = DIR_UP;
          end else if (w_go_down) begin
            w_state_next    = ST_MOVING_DOWN;
            w_timer_next    = TRAVEL_LOAD;
            w_last_dir_next = DIR_DOWN;
          end else begin
            w_state_next = ST_IDLE;
            w_timer_next = '0;
          end
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // Clearing the arrival floor wins over a call for it in the same cycle.
  assign w_pending_next = (r_pending | (w_latch ? w_call_oh : 4'b0000)) & ~w_clear_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_floor    <= 2'd0;
      r_pending  <= 4'b0000;
      r_timer    <= '0;
      r_last_dir <= DIR_UP;
    end else begin
      r_state    <= w_state_next;
      r_floor    <= w_floor_next;
      r_pending  <= w_pending_next;
      r_timer    <= w_timer_next;
      r_last_dir <= w_last_dir_next;
    end
  end

  assign ctrl.current_floor = r_floor;
  assign ctrl.motor_up      = (r_state == ST_MOVING_UP);
  assign ctrl.motor_down    = (r_state == ST_MOVING_DOWN);
  assign ctrl.door_open     = (r_state == ST_DOOR_OPEN);
  assign ctrl.pending       = r_pending;
  assign ctrl.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for the car controller with short travel/dwell times: table rows and hand
// sequences queue expected outputs per cycle, compared after every clock edge.
module tb_elevator_car_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  elevator_car_controller_if bus ();

  elevator_car_controller #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3),
    .CNT_W        (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] uod;
    logic [1:0] cf;
    int         n;
    logic [9:0] exp;
    string      name;
  } vec_t;

  logic [9:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Expected output word: {floor, motor_up, motor_down, door_open, pending, busy}
  function automatic logic [9:0] mk(input logic [1:0] fl, input logic up, input logic dn,
                                    input logic door, input logic [3:0] p, input logic busy);
    return {fl, up, dn, door, p, busy};
  endfunction

  function automatic logic [9:0] e_idle(input logic [1:0] fl, input logic [3:0] p);
    return mk(fl, 1'b0, 1'b0, 1'b0, p, 1'b0);
  endfunction
  function automatic logic [9:0] e_up(input logic [1:0] fl, input logic [3:0] p);
    return mk(fl, 1'b1, 1'b0, 1'b0, p, 1'b1);
  endfunction
  function automatic logic [9:0] e_dn(input logic [1:0] fl, input logic [3:0] p);
    return mk(fl, 1'b0, 1'b1, 1'b0, p, 1'b1);
  endfunction
  function automatic logic [9:0] e_door(input logic [1:0] fl, input logic [3:0] p);
    return mk(fl, 1'b0, 1'b0, 1'b1, p, 1'b1);
  endfunction

  function automatic logic [9:0] actual();
    return {bus.current_floor, bus.motor_up, bus.motor_down, bus.door_open, bus.pending, bus.busy};
  endfunction

  task automatic check(input string name);
    logic [9:0] e;
    logic [9:0] a;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, actual=%b", name, actual());
    end else begin
      e = exp_q.pop_front();
      a = actual();
      if (a === e) begin
        n_pass++;
        $display("t=%0t %s ok out=%b", $time, name, a);
      end else begin
        $display("FAIL %s: actual=%b required=%b (floor,up,dn,door,pending,busy)", name, a, e);
      end
    end
  endtask

  task automatic run(input logic [1:0] uod, input logic [1:0] cf, input int n,
                     input logic [9:0] exp, input string name);
    for (int k = 0; k < n; k++) begin
      bus.up_or_down = uod;
      bus.call_floor = cf;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      check(name);
    end
  endtask

  // The car must never drive past the end floors, and the three actuators are exclusive.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int'(bus.motor_up) + int'(bus.motor_down) + int'(bus.door_open)) > 1 ||
          (bus.motor_up && bus.current_floor == 2'd3) ||
          (bus.motor_down && bus.current_floor == 2'd0)) begin
        n_total++;
        $display("FAIL exclusivity/range: actual up=%b dn=%b door=%b floor=%0d required legal combination",
                 bus.motor_up, bus.motor_down, bus.door_open, bus.current_floor);
      end
    end
  end

  vec_t tbl[$];

  initial begin
    tbl.push_back('{2'b11, 2'd0, 1, e_door(2'd0, 4'h0), "same_floor_call_opens"});
    tbl.push_back('{2'b00, 2'd0, 2, e_door(2'd0, 4'h0), "door_dwell"});
    tbl.push_back('{2'b00, 2'd0, 1, e_idle(2'd0, 4'h0), "door_close_idle"});
    tbl.push_back('{2'b10, 2'd3, 2, e_idle(2'd0, 4'h0), "reserved_code_ignored"});
    tbl.push_back('{2'b01, 2'd2, 1, e_idle(2'd0, 4'h4), "latch_call_f2"});
    tbl.push_back('{2'b00, 2'd0, 4, e_up(2'd0, 4'h4),   "up_leg_f0"});
    tbl.push_back('{2'b00, 2'd0, 4, e_up(2'd1, 4'h4),   "up_leg_f1"});
    tbl.push_back('{2'b00, 2'd0, 3, e_door(2'd2, 4'h0), "arrive_f2_door"});
    tbl.push_back('{2'b00, 2'd0, 1, e_idle(2'd2, 4'h0), "idle_at_f2"});

    bus.up_or_down = 2'b00;
    bus.call_floor = 2'd0;
    #1 rst_n = 1'b0;
    #11;
    exp_q.push_back(10'b0);
    check("reset_state");
    rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i].uod, tbl[i].cf, tbl[i].n, tbl[i].exp, tbl[i].name);

    // Dwell extension: same-floor call on the second door cycle gives 5 open cycles.
    run(2'b11, 2'd2, 1, e_door(2'd2, 4'h0), "ext_door1");
    run(2'b00, 2'd0, 1, e_door(2'd2, 4'h0), "ext_door2");
    run(2'b11, 2'd2, 1, e_door(2'd2, 4'h0), "ext_door3_reload");
    run(2'b00, 2'd0, 2, e_door(2'd2, 4'h0), "ext_door4_5");
    run(2'b00, 2'd0, 1, e_idle(2'd2, 4'h0), "ext_close");

    // Return to floor 0 going down.
    run(2'b01, 2'd0, 1, e_idle(2'd2, 4'h1), "latch_call_f0");
    run(2'b00, 2'd0, 4, e_dn(2'd2, 4'h1),   "down_leg_f2");
    run(2'b00, 2'd0, 4, e_dn(2'd1, 4'h1),   "down_leg_f1");
    run(2'b00, 2'd0, 3, e_door(2'd0, 4'h0), "arrive_f0_door");
    run(2'b00, 2'd0, 1, e_idle(2'd0, 4'h0), "idle_at_f0");

    // Collective sweep: up to 3 with an intermediate stop, then reverse to 0.
    run(2'b01, 2'd3, 1, e_idle(2'd0, 4'h8), "sweep_latch_f3");
    run(2'b00, 2'd0, 4, e_up(2'd0, 4'h8),   "sweep_up_f0");
    run(2'b00, 2'd0, 1, e_up(2'd1, 4'h8),   "sweep_up_f1a");
    run(2'b01, 2'd0, 1, e_up(2'd1, 4'h9),   "sweep_call_f0_moving");
    run(2'b11, 2'd2, 1, e_up(2'd1, 4'hD),   "sweep_call_f2_moving");
    run(2'b00, 2'd0, 1, e_up(2'd1, 4'hD),   "sweep_up_f1d");
    run(2'b00, 2'd0, 3, e_door(2'd2, 4'h9), "sweep_stop_f2");
    run(2'b00, 2'd0, 4, e_up(2'd2, 4'h9),   "sweep_up_f2");
    run(2'b00, 2'd0, 3, e_door(2'd3, 4'h1), "sweep_stop_f3");
    run(2'b00, 2'd0, 4, e_dn(2'd3, 4'h1),   "sweep_down_f3");
    run(2'b00, 2'd0, 4, e_dn(2'd2, 4'h1),   "sweep_down_f2");
    run(2'b00, 2'd0, 4, e_dn(2'd1, 4'h1),   "sweep_down_f1");
    run(2'b00, 2'd0, 3, e_door(2'd0, 4'h0), "sweep_stop_f0");
    run(2'b00, 2'd0, 1, e_idle(2'd0, 4'h0), "sweep_idle");

    // Arrival at floor 2 coinciding with a fresh call for floor 2.
    run(2'b01, 2'd2, 1, e_idle(2'd0, 4'h4), "coinc_latch_f2");
    run(2'b00, 2'd0, 4, e_up(2'd0, 4'h4),   "coinc_up_f0");
    run(2'b00, 2'd0, 4, e_up(2'd1, 4'h4),   "coinc_up_f1");
    run(2'b01, 2'd2, 1, e_door(2'd2, 4'h0), "coinc_clear_beats_set");
    run(2'b00, 2'd0, 2, e_door(2'd2, 4'h0), "coinc_door");
    run(2'b00, 2'd0, 2, e_idle(2'd2, 4'h0), "coinc_no_reopen");

    // Asynchronous reset in the middle of an upward move.
    run(2'b01, 2'd3, 1, e_idle(2'd2, 4'h8), "rst_latch_f3");
    run(2'b00, 2'd0, 2, e_up(2'd2, 4'h8),   "rst_moving_up");
    #3 rst_n = 1'b0;
    #1;
    exp_q.push_back(10'b0);
    check("async_reset_no_clock");
    #2 rst_n = 1'b1;
    run(2'b00, 2'd0, 2, e_idle(2'd0, 4'h0), "after_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
